// File: rtl/therm_ramp_gen.sv
// therm_ramp_gen: one-segment-per-step thermometer ramp generator; define THERM_SAT_EN to clamp out-of-range targets instead of rejecting them
module therm_ramp_gen #(
  parameter int N = 8,
  parameter int STEP_DIV = 1,
  localparam int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] target_in,
  input  logic         target_valid,
  output logic         target_ready,
  output logic [N-1:0] codeOut,
  output logic [W-1:0] level,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [W-1:0] LMAX = W'(N);
  localparam logic [CW-1:0] CLAST = CW'(STEP_DIV - 1);
  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} stateT;
  stateT state, stateNext;
  logic [W-1:0] tgt, tgtNext, levelNext, reqT;
  logic [N-1:0] codeNext;
  logic [CW-1:0] cnt, cntNext;
  logic doneNext, errNext, reject, wrap, up;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tgt <= '0;
      cnt <= '0;
      level <= '0;
      codeOut <= '0;
      done <= 1'b0;
      err <= 1'b0;
      target_ready <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= stateNext;
      tgt <= tgtNext;
      cnt <= cntNext;
      level <= levelNext;
      codeOut <= codeNext;
      done <= doneNext;
      err <= errNext;
      target_ready <= stateNext == IDLE;
      busy <= stateNext != IDLE;
    end
  end
  always_comb begin
`ifdef THERM_SAT_EN
    reqT = target_in > LMAX ? LMAX : target_in;
    reject = 1'b0;
`else
    reqT = target_in;
    reject = target_in > LMAX;
`endif
    wrap = cnt == CLAST;
    up = state == RAMP_UP;
    stateNext = state;
    tgtNext = tgt;
    cntNext = cnt;
    levelNext = level;
    codeNext = codeOut;
    doneNext = 1'b0;
    errNext = 1'b0;
    if (state == IDLE) begin
      if (target_valid) begin
        errNext = reject;
        doneNext = !reject && reqT == level;
        if (!reject && reqT != level) begin
          tgtNext = reqT;
          cntNext = '0;
          stateNext = reqT > level ? RAMP_UP : RAMP_DOWN;
        end
      end
    end else begin
      cntNext = wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        levelNext = up ? level + 1'b1 : level - 1'b1;
        codeNext = up ? {codeOut[N-2:0], 1'b1} : {1'b0, codeOut[N-1:1]};
        if (levelNext == tgt) begin
          stateNext = IDLE;
          doneNext = 1'b1;
        end
      end
    end
  end
endmodule
